// File: rtl/fp32_divider.sv
// fp32_divider -- IEEE-754 binary32 divider, flush-to-zero, truncating.
// Special cases (NaN, zero, inf, denormal) finish on the acceptance edge;
// normal operands take a 25-step restoring mantissa division plus one pack
// cycle, so out_valid rises exactly 26 edges after acceptance.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b latched on acceptance)
//   a, b                  dividend / divisor bit patterns
//   out_valid / out_ready result handshake; result held until consumed
//   result, div_by_zero   quotient and finite-nonzero/zero flag

// Field split plus classification of one binary32 pattern.
module fp32_decoder (
  input  logic [31:0] x,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [22:0] man,
  output logic        is_zero,
  output logic        is_denorm,
  output logic        is_inf,
  output logic        is_nan
);
  assign sign      = x[31];
  assign exp       = x[30:23];
  assign man       = x[22:0];
  assign is_zero   = (exp == 8'h00) && (man == 23'd0);
  assign is_denorm = (exp == 8'h00) && (man != 23'd0);
  assign is_inf    = (exp == 8'hFF) && (man == 23'd0);
  assign is_nan    = (exp == 8'hFF) && (man != 23'd0);
endmodule

module fp32_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, DIVIDE, PACK, DONE} state_t;

  state_t state, state_nxt;

  logic              sa, sb, za, zb, da, db, ia, ib, na, nb;
  logic [7:0]        ea, eb;
  logic [22:0]       ma, mb;

  fp32_decoder dec_a (.x(a), .sign(sa), .exp(ea), .man(ma), .is_zero(za),
                      .is_denorm(da), .is_inf(ia), .is_nan(na));
  fp32_decoder dec_b (.x(b), .sign(sb), .exp(eb), .man(mb), .is_zero(zb),
                      .is_denorm(db), .is_inf(ib), .is_nan(nb));

  logic              accept, a_zero, b_zero, special, spec_dbz;
  logic [31:0]       spec_res;
  logic [4:0]        cnt;
  logic [25:0]       rem, diff, rem_sel;
  logic [23:0]       dvs;
  logic [24:0]       q;
  logic              ge, sign_q;
  logic signed [9:0] exp_q, e_adj;
  logic [22:0]       mant;
  logic [31:0]       pack_res;

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Denormals count as zero from here on.
  assign a_zero  = za | da;
  assign b_zero  = zb | db;
  assign special = na | nb | ia | ib | a_zero | b_zero;

  always_comb begin
    spec_res = {sa ^ sb, 31'd0};
    spec_dbz = 1'b0;
    if (na || nb || (a_zero && b_zero) || (ia && ib)) begin
      spec_res = 32'h7FC0_0000;
    end else if (b_zero) begin
      spec_res = {sa ^ sb, 8'hFF, 23'd0};
      spec_dbz = !ia;                       // inf/0 is plain inf
    end else if (ia) begin
      spec_res = {sa ^ sb, 8'hFF, 23'd0};
    end
    // remaining cases (x/inf, 0/x) keep the signed-zero default
  end

  // Restoring step: remainder stays below 2*divisor, so diff[25] is the
  // borrow of rem - dvs.
  assign diff    = rem - {2'b00, dvs};
  assign ge      = !diff[25];
  assign rem_sel = ge ? diff : rem;

  always_comb begin
    if (q[24]) begin
      mant  = q[23:1];
      e_adj = exp_q;
    end else begin
      mant  = q[22:0];
      e_adj = exp_q - 10'sd1;
    end
    if (e_adj >= 10'sd255)    pack_res = {sign_q, 8'hFF, 23'd0};
    else if (e_adj <= 10'sd0) pack_res = {sign_q, 31'd0};
    else                      pack_res = {sign_q, e_adj[7:0], mant};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt == 5'd24) state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= 32'd0;
      div_by_zero <= 1'b0;
      cnt         <= 5'd0;
      rem         <= 26'd0;
      dvs         <= 24'd0;
      q           <= 25'd0;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt    <= 5'd0;
          q      <= 25'd0;
          rem    <= {3'b001, ma};
          dvs    <= {1'b1, mb};
          sign_q <= sa ^ sb;
          exp_q  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
          if (special) begin
            result      <= spec_res;
            div_by_zero <= spec_dbz;
          end
        end
        DIVIDE: begin
          q   <= {q[23:0], ge};
          rem <= rem_sel << 1;
          cnt <= cnt + 5'd1;
        end
        PACK: begin
          result      <= pack_res;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_divider.sv
// Directed bench for fp32_divider: vector table of operand pairs with
// hand-computed quotients, flags and latencies, plus hand-written
// sequences for back-pressure and mid-division reset.
module tb_fp32_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        div_by_zero;

  fp32_divider dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    int          lat;   // edges from acceptance until out_valid is high
  } vec_t;

  vec_t vecs[19];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a/b until accepted; inputs are scrambled right after.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb);
    int w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    chk("in_ready before issue", {31'd0, in_ready}, 32'd1);
    a = va; b = vb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid after release", {31'd0, out_valid}, 32'd0);
    chk("in_ready after release", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    issue(v.a, v.b);
    wait_out(lat);
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d result", idx), result, v.res);
    chk($sformatf("v%0d div_by_zero", idx), {31'd0, div_by_zero}, {31'd0, v.dbz});
    release_out();
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26};
    vecs[2]  = '{32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 1'b0, 26};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 0};
    vecs[4]  = '{32'hBF800000, 32'h80000000, 32'h7F800000, 1'b1, 0};
    vecs[5]  = '{32'hBF800000, 32'h00000001, 32'hFF800000, 1'b1, 0};
    vecs[6]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 0};
    vecs[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 0};
    vecs[8]  = '{32'hFF800001, 32'h3F800000, 32'h7FC00000, 1'b0, 0};
    vecs[9]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 26};
    vecs[10] = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 26};
    vecs[11] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 0};
    vecs[12] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 0};
    vecs[13] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 0};
    vecs[14] = '{32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, 26};
    vecs[15] = '{32'hC0400000, 32'h3FC00000, 32'hC0000000, 1'b0, 26};
    vecs[16] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 0};
    vecs[17] = '{32'h3FFFFFFF, 32'h3F800000, 32'h3FFFFFFF, 1'b0, 26};
    vecs[18] = '{32'h3F800000, 32'h3FFFFFFF, 32'h3F000000, 1'b0, 26};

    // Reset state
    tick(); tick();
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-pressure: result held for 10 cycles, new operands ignored
    issue(32'h40C00000, 32'h40000000);
    wait_out(lat);
    chk("hold latency", lat, 26);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h00000000;
      tick();
      chk("hold out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold result", result, 32'h40400000);
      chk("hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    tick(); tick(); tick();
    chk("no queued op", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a division
    issue(32'h3F800000, 32'h40400000);
    for (int i = 0; i < 10; i++) tick();
    chk("mid-divide busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort in_ready during reset", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("abort in_ready after reset", {31'd0, in_ready}, 32'd1);
    run_vec(vecs[1], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
